// File: rtl/rv32_dmem_responder.sv
// Data-memory responder: word RAM behind a one-outstanding load/store port with optional wait states.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module rv32_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [AW-1:0]  idx_q;
    logic [1:0]     lo_q;
    logic [31:0]    wdata_q;
    logic [1:0]     size_q;
    logic           we_q;
    logic           uns_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [31:0]    off;
    logic           unused;
    logic           trap;
    logic           wr_en;
    logic [3:0]     be;
    logic [31:0]    wd;
    logic [31:0]    word;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [31:0]    load_v;

    // Address bits above the RAM index alias silently.
    assign off    = req_addr - BASE_ADDR;
    assign unused = ^off[31:AW+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            cnt       <= '0;
            idx_q     <= '0;
            lo_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (req_valid) begin
                        idx_q   <= off[AW+1:2];
                        lo_q    <= off[1:0];
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        if (WAIT_STATES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state     <= WAIT;
                            cnt       <= WS_LOAD;
                            req_ready <= 1'b0;
                            rsp_valid <= 1'b0;
                        end
                    end else begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = (size_q == 2'b01 && lo_q[0])
               || (size_q[1] && lo_q != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        unique case (size_q)
            2'b00: begin
                be = 4'b0001 << lo_q;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = lo_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
            end
        endcase
    end

    // Commit on the edge that closes RESP; a reset on that edge drops it.
    assign wr_en = (state == RESP) && we_q && !trap && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx_q][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    assign word   = mem[idx_q];
    assign byte_v = word[{lo_q, 3'b000} +: 8];
    assign half_v = lo_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_v = word;
        unique case (size_q)
            2'b00: begin
                load_v = uns_q ? {24'd0, byte_v}
                               : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                load_v = uns_q ? {16'd0, half_v}
                               : {{16{half_v[15]}}, half_v};
            end
            default: begin
                load_v = word;
            end
        endcase
    end

    assign rsp_rdata = (rsp_valid && !we_q && !trap) ? load_v : 32'd0;
    assign err       = rsp_valid && trap;
    assign busy      = ~req_ready;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench: zero-wait and three-wait-state responders side by side.
module tb_rv32_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        v0, we0, uns0, rdy0, rv0, busy0, err0;
    logic [31:0] a0, wd0, rd0;
    logic [1:0]  sz0;
    logic        v3, we3, uns3, rdy3, rv3, busy3, err3;
    logic [31:0] a3, wd3, rd3;
    logic [1:0]  sz3;

    rv32_dmem_responder #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .req_size(sz0), .req_unsigned(uns0),
        .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0),
        .busy(busy0), .err(err0)
    );

    rv32_dmem_responder #(.WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_we(we3), .req_addr(a3),
        .req_wdata(wd3), .req_size(sz3), .req_unsigned(uns3),
        .req_ready(rdy3), .rsp_valid(rv3), .rsp_rdata(rd3),
        .busy(busy3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put0(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic u);
        v0 = 1'b1; we0 = we; a0 = a; wd0 = wd; sz0 = sz; uns0 = u;
    endtask

    task automatic put3(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic u);
        v3 = 1'b1; we3 = we; a3 = a; wd3 = wd; sz3 = sz; uns3 = u;
    endtask

    task automatic txn0(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic u, output logic [31:0] rd,
                        output logic e);
        @(negedge clk);
        put0(we, a, wd, sz, u);
        chk("rdy0_pre", rdy0, 1);
        @(negedge clk);
        v0 = 1'b0;
        chk("rsp0_lat", rv0, 1);
        rd = rd0;
        e  = err0;
    endtask

    task automatic txn3(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic u, output logic [31:0] rd);
        int lat;
        lat = 0;
        rd  = 32'hx;
        @(negedge clk);
        put3(we, a, wd, sz, u);
        chk("rdy3_pre", rdy3, 1);
        @(negedge clk);
        v3 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (lat == 0) begin
                if (rv3) begin
                    lat = c;
                    rd  = rd3;
                    chk("rdy3_resp", rdy3, 1);
                end else begin
                    if (c <= 3) begin
                        chk("rdy3_wait", rdy3, 0);
                        chk("busy3_wait", busy3, 1);
                    end
                    @(negedge clk);
                end
            end
        end
        chk("lat3", lat, 4);
    endtask

    logic [31:0] rd;
    logic        e;
    logic [31:0] exp4 [4];
    int          seen;

    initial begin
        v0 = 0; we0 = 0; a0 = 0; wd0 = 0; sz0 = 0; uns0 = 0;
        v3 = 0; we3 = 0; a3 = 0; wd3 = 0; sz3 = 0; uns3 = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rdy0", rdy0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_rv0", rv0, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_err0", err0, 0);
        chk("rst_rdy3", rdy3, 1);
        rst = 1'b0;

        // word store / load
        txn0(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, rd, e);
        chk("sw_rdata", rd, 0);
        txn0(0, 32'h10, 0, 2'b10, 0, rd, e);
        chk("lw_10", rd, 32'hDEADBEEF);
        chk("lw_err", e, 0);

        // byte lanes and extension
        txn0(1, 32'h13, 32'hAAAAAA80, 2'b00, 0, rd, e);
        txn0(0, 32'h13, 0, 2'b00, 0, rd, e);
        chk("lb_13", rd, 32'hFFFFFF80);
        txn0(0, 32'h13, 0, 2'b00, 1, rd, e);
        chk("lbu_13", rd, 32'h00000080);
        txn0(0, 32'h10, 0, 2'b10, 0, rd, e);
        chk("lw_after_sb", rd, 32'h80ADBEEF);
        txn0(0, 32'h11, 0, 2'b00, 0, rd, e);
        chk("lb_11", rd, 32'hFFFFFFBE);
        txn0(0, 32'h10, 0, 2'b00, 1, rd, e);
        chk("lbu_10", rd, 32'h000000EF);
        txn0(0, 32'h12, 0, 2'b01, 0, rd, e);
        chk("lh_12", rd, 32'hFFFF80AD);
        txn0(0, 32'h12, 0, 2'b01, 1, rd, e);
        chk("lhu_12", rd, 32'h000080AD);
        txn0(1, 32'h12, 32'hFFFF1234, 2'b01, 0, rd, e);
        txn0(0, 32'h10, 0, 2'b11, 0, rd, e);
        chk("lw_after_sh", rd, 32'h1234BEEF);

        // back-to-back loads at zero wait states
        for (int i = 0; i < 4; i++) begin
            exp4[i] = 32'h0101_0101 * (i + 1) + 32'h9000_0000;
            txn0(1, 32'h40 + 4 * i, exp4[i], 2'b10, 0, rd, e);
        end
        @(negedge clk);
        put0(0, 32'h40, 0, 2'b10, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("b2b_rv", rv0, 1);
            chk("b2b_rdy", rdy0, 1);
            chk("b2b_data", rd0, exp4[i-1]);
            if (i < 4) put0(0, 32'h40 + 4 * i, 0, 2'b10, 0);
            else v0 = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end", rv0, 0);

        // wait-state timing and reset abort
        txn3(1, 32'h20, 32'hCAFEF00D, 2'b10, 0, rd);
        txn3(0, 32'h20, 0, 2'b10, 0, rd);
        chk("ws_lw_20", rd, 32'hCAFEF00D);
        @(negedge clk);
        put3(1, 32'h20, 32'h12345678, 2'b10, 0);
        @(negedge clk);
        v3 = 1'b0;
        chk("abort_n1", rv3, 0);
        @(negedge clk);
        chk("abort_n2", rv3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rdy", rdy3, 1);
        chk("abort_busy", busy3, 0);
        chk("abort_rv", rv3, 0);
        chk("abort_rd", rd3, 0);
        chk("abort_err", err3, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv3) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        txn3(0, 32'h20, 0, 2'b10, 0, rd);
        chk("abort_old", rd, 32'hCAFEF00D);

        // misalignment and aliasing
        txn0(1, 32'h10, 32'h11223344, 2'b10, 0, rd, e);
        txn0(0, 32'h11, 0, 2'b01, 0, rd, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh_11_err", e, 1);
        chk("lh_11_rd", rd, 0);
`else
        chk("lh_11_err", e, 0);
        chk("lh_11_rd", rd, 32'h00003344);
`endif
        txn0(1, 32'h11, 32'h0000AAAA, 2'b01, 0, rd, e);
        txn0(0, 32'h10, 0, 2'b10, 0, rd, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("sh_11_ram", rd, 32'h11223344);
`else
        chk("sh_11_ram", rd, 32'h1122AAAA);
`endif
        txn0(1, 32'h1010, 32'h55667788, 2'b10, 0, rd, e);
        txn0(0, 32'h10, 0, 2'b10, 0, rd, e);
        chk("alias_10", rd, 32'h55667788);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
